counter_sched: RTL
==================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter xLen, default 64: counter data width.
REQ-002 Parameter NREQ, default 4: number of requesters; IDW = $clog2(NREQ).
REQ-003 Parameter TIMEOUT, default 16: maximum cycles waited for a READ result.
REQ-004 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high; SHALL clear all state immediately when asserted.
REQ-006 req  in  NREQ  per-requester request, level; held until granted.
REQ-007 req_op  in  2*NREQ  per-requester opcode: 00 INIT, 01 START, 10 READ, 11 reserved.
REQ-008 req_data  in  xLen*NREQ  per-requester INIT value.
REQ-009 gnt  out  NREQ  one-hot grant pulse, 1 cycle.
REQ-010 rsp_valid  out  1  response pulse, 1 cycle.
REQ-011 rsp_id  out  IDW  index of the responding requester.
REQ-012 rsp_data  out  xLen  READ result; 0 for other ops.
REQ-013 rsp_err  out  1  error flag, qualified by rsp_valid.
REQ-014 ctr_init, ctr_start, ctr_return_current_count  out  1 each  counter control pulses.
REQ-015 ctr_init_val  out  xLen  counter init value.
REQ-016 ctr_current_count  in  xLen; ctr_count_valid  in  1  counter result and valid.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req bit is set, the block SHALL grant one requester by round-robin, pulse gnt, latch its op, data and id, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin: after reset, requester 0 SHALL have highest priority; after each grant, highest priority SHALL move to (granted index + 1) mod NREQ.
REQ-020 A running flag SHALL be cleared by reset, set on successful START completion, and never cleared otherwise.
REQ-021 ISSUE, INIT with running=0: ctr_init_val SHALL be set to the latched data, ctr_init SHALL pulse for 1 cycle, and the FSM SHALL go to WAIT for exactly 3 cycles, then to RESP with rsp_err=0.
REQ-022 ISSUE, START with running=0: ctr_start SHALL pulse for 1 cycle, the FSM SHALL wait 2 cycles, set running, then go to RESP with rsp_err=0.
REQ-023 ISSUE, READ with running=1: ctr_return_current_count SHALL pulse for 1 cycle; WAIT SHALL end on the first cycle ctr_count_valid is sampled as 0->1; ctr_current_count SHALL be captured on that cycle into rsp_data.
REQ-024 Errors: INIT with running=1, START with running=1, READ with running=0, and op 11 SHALL issue no counter pulse and SHALL go straight to RESP with rsp_err=1.
REQ-025 RESP: rsp_valid SHALL be 1 for exactly 1 cycle, with rsp_id, rsp_data and rsp_err stable; the FSM SHALL then return to IDLE.
REQ-026 Grant-to-response latency: INIT 5 cycles, START 4 cycles, error 2 cycles, READ 2 cycles + counter latency.
REQ-027 At most one counter pulse SHALL be high in any cycle, and at most one operation SHALL be outstanding.
REQ-028 ctr_init_val SHALL hold its last value outside INIT.
REQ-029 Changes to req while the FSM is not in IDLE SHALL be ignored until IDLE.

Reset
REQ-030 While reset is asserted: FSM=IDLE, running=0, RR pointer=0, and gnt, rsp_valid, rsp_id, rsp_data, rsp_err, all ctr_* pulses and ctr_init_val SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no rsp_valid; the counter is reset on the same reset net.

Configuration
REQ-032 With macro COUNTER_SCHED_TIMEOUT_EN defined, a READ WAIT exceeding TIMEOUT cycles SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-033 Without COUNTER_SCHED_TIMEOUT_EN, READ WAIT SHALL wait indefinitely for ctr_count_valid, and no timeout logic SHALL be synthesized.

Verification
REQ-034 After reset, req=0001 INIT data=0x10 -> gnt=0001; ctr_init pulses with ctr_init_val=0x10; rsp_valid 5 cycles after gnt with id=0, err=0.
REQ-035 START from requester 1, then READ from requester 2 with the counter model returning 0x25 -> START response err=0; READ response id=2, data=0x25, err=0.
REQ-036 req=1111 held, all READ, running=1 -> grants in order 0,1,2,3,0; exactly one response per grant.
REQ-037 READ before START; INIT after START; op 11 -> each gives rsp_err=1 two cycles after gnt, with no ctr_* pulse.
REQ-038 COUNTER_SCHED_TIMEOUT_EN defined, ctr_count_valid stuck at 0 -> rsp_err=1 after 16 WAIT cycles; undefined -> no response, FSM remains in WAIT.
REQ-039 reset asserted during a READ WAIT -> all outputs 0 immediately; no rsp_valid; the next request after reset is served normally with the RR pointer at 0.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that serialises INIT / START / READ
// requests from NREQ requesters onto a single counter control interface.
// One operation is in flight at a time; each grant yields exactly one response.
// Optional feature: define COUNTER_SCHED_TIMEOUT_EN to bound the READ wait
// to TIMEOUT cycles (rsp_err=1, rsp_data=0 on expiry).
module counter_sched #(
    parameter int xLen    = 64,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [xLen*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [xLen-1:0]        rsp_data,
    output logic                   rsp_err,
    output logic                   ctr_init,
    output logic                   ctr_start,
    output logic                   ctr_return_current_count,
    output logic [xLen-1:0]        ctr_init_val,
    input  logic [xLen-1:0]        ctr_current_count,
    input  logic                   ctr_count_valid
);

    localparam logic [1:0] OP_INIT  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Wait counter covers the fixed INIT/START waits and the READ timeout.
    localparam int CW = $clog2(TIMEOUT + 1) + 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state, w_state;
    logic [IDW-1:0]     r_ptr, w_ptr;
    logic               r_running, w_running;
    logic [1:0]         r_op, w_op;
    logic [xLen-1:0]    r_data, w_data;
    logic [IDW-1:0]     r_id, w_id;
    logic               r_err, w_err;
    logic [xLen-1:0]    r_cap, w_cap;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic               r_cv_q;

    logic [NREQ-1:0]    r_gnt, w_gnt;
    logic               r_rsp_valid, w_rsp_valid;
    logic [IDW-1:0]     r_rsp_id, w_rsp_id;
    logic [xLen-1:0]    r_rsp_data, w_rsp_data;
    logic               r_rsp_err, w_rsp_err;
    logic               r_ctr_init, w_ctr_init;
    logic               r_ctr_start, w_ctr_start;
    logic               r_ctr_ret, w_ctr_ret;
    logic [xLen-1:0]    r_ctr_init_val, w_ctr_init_val;

    logic               w_found;
    logic [IDW-1:0]     w_gidx;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_ptr_nx;
    logic               w_rise;

    // Result is taken only on a 0->1 edge of the counter valid.
    assign w_rise = ctr_count_valid & ~r_cv_q;

    // Round-robin pick: scan from r_ptr upward, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NREQ))
                w_sum = w_sum - (IDW+1)'(NREQ);
            if (!w_found && req[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IDW-1:0];
            end
        end
        w_ptr_nx = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
    end

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        w_state        = r_state;
        w_ptr          = r_ptr;
        w_running      = r_running;
        w_op           = r_op;
        w_data         = r_data;
        w_id           = r_id;
        w_err          = r_err;
        w_cap          = r_cap;
        w_cnt          = r_cnt;
        w_gnt          = '0;
        w_rsp_valid    = 1'b0;
        w_rsp_id       = r_rsp_id;
        w_rsp_data     = r_rsp_data;
        w_rsp_err      = r_rsp_err;
        w_ctr_init     = 1'b0;
        w_ctr_start    = 1'b0;
        w_ctr_ret      = 1'b0;
        w_ctr_init_val = r_ctr_init_val;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt   = NREQ'(1) << w_gidx;
                    w_op    = req_op[{w_gidx, 1'b0} +: 2];
                    w_data  = req_data[w_gidx*xLen +: xLen];
                    w_id    = w_gidx;
                    w_ptr   = w_ptr_nx;
                    w_cap   = '0;
                    w_err   = 1'b0;
                    w_state = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_cnt = '0;
                // Legal ops pulse the counter and wait; everything else errors out.
                if (r_op == OP_INIT && !r_running) begin
                    w_ctr_init     = 1'b1;
                    w_ctr_init_val = r_data;
                    w_state        = S_WAIT;
                end else if (r_op == OP_START && !r_running) begin
                    w_ctr_start = 1'b1;
                    w_state     = S_WAIT;
                end else if (r_op == OP_READ && r_running) begin
                    w_ctr_ret = 1'b1;
                    w_state   = S_WAIT;
                end else begin
                    w_err   = 1'b1;
                    w_state = S_RESP;
                end
            end

            S_WAIT: begin
                w_cnt = r_cnt + CW'(1);
                if (r_op == OP_INIT) begin
                    if (r_cnt == CW'(2))
                        w_state = S_RESP;
                end else if (r_op == OP_START) begin
                    if (r_cnt == CW'(1)) begin
                        w_running = 1'b1;
                        w_state   = S_RESP;
                    end
                end else begin
                    if (w_rise) begin
                        w_cap   = ctr_current_count;
                        w_state = S_RESP;
                    end
`ifdef COUNTER_SCHED_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        w_err   = 1'b1;
                        w_cap   = '0;
                        w_state = S_RESP;
                    end
`endif
                end
            end

            S_RESP: begin
                w_rsp_valid = 1'b1;
                w_rsp_id    = r_id;
                w_rsp_data  = r_cap;
                w_rsp_err   = r_err;
                w_state     = S_IDLE;
            end

            default: w_state = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_running      <= 1'b0;
            r_op           <= '0;
            r_data         <= '0;
            r_id           <= '0;
            r_err          <= 1'b0;
            r_cap          <= '0;
            r_cnt          <= '0;
            r_cv_q         <= 1'b0;
            r_gnt          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_ctr_init     <= 1'b0;
            r_ctr_start    <= 1'b0;
            r_ctr_ret      <= 1'b0;
            r_ctr_init_val <= '0;
        end else begin
            r_state        <= w_state;
            r_ptr          <= w_ptr;
            r_running      <= w_running;
            r_op           <= w_op;
            r_data         <= w_data;
            r_id           <= w_id;
            r_err          <= w_err;
            r_cap          <= w_cap;
            r_cnt          <= w_cnt;
            r_cv_q         <= ctr_count_valid;
            r_gnt          <= w_gnt;
            r_rsp_valid    <= w_rsp_valid;
            r_rsp_id       <= w_rsp_id;
            r_rsp_data     <= w_rsp_data;
            r_rsp_err      <= w_rsp_err;
            r_ctr_init     <= w_ctr_init;
            r_ctr_start    <= w_ctr_start;
            r_ctr_ret      <= w_ctr_ret;
            r_ctr_init_val <= w_ctr_init_val;
        end
    end

    assign gnt                      = r_gnt;
    assign rsp_valid                = r_rsp_valid;
    assign rsp_id                   = r_rsp_id;
    assign rsp_data                 = r_rsp_data;
    assign rsp_err                  = r_rsp_err;
    assign ctr_init                 = r_ctr_init;
    assign ctr_start                = r_ctr_start;
    assign ctr_return_current_count = r_ctr_ret;
    assign ctr_init_val             = r_ctr_init_val;

endmodule
